// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Used by muldiv_unit (optional macro MULDIV_FAST_MUL_EN), its interface and bench.
package muldiv_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic rs1_signed(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic rs2_signed(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Decoder-to-muldiv handshake: strobe, op, operands and tag in; busy, done, result out.
interface muldiv_unit_if
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            start;
  muldiv_op_t      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit_seq_divider.sv
// Unsigned restoring divider core: load latches operands, each step retires one quotient bit.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [WIDTH:0]   part, diff;

  // diff[WIDTH] is the borrow: set only when the partial remainder is below the divisor
  always_comb begin
    part = {rem_q, quo_q[WIDTH-1]};
    diff = part - {1'b0, dvs_q};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= part[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit; `define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ITER = XLEN
) (
  input  logic         clock,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(ITER) + 1;

  muldiv_state_t     state_q, state_d;
  muldiv_op_t        op_q;
  logic [XLEN-1:0]   mcand_q, result_q;
  logic [2*XLEN-1:0] prod_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q, dvd_neg_q;
  logic [4:0]        rd_q, rd_out_q;

  logic              accept, a_neg, b_neg, div0, ovf, special, last;
  logic              div_load, div_step;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;
  logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix, res_fix;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN:0]     mul_sum;

  function automatic logic [XLEN-1:0] pick(input muldiv_op_t op, input logic [2*XLEN-1:0] p,
                                           input logic [XLEN-1:0] q, input logic [XLEN-1:0] r);
    logic [XLEN-1:0] v;
    case (op)
      OP_MUL:                       v = p[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: v = p[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              v = q;
      default:                      v = r;
    endcase
    return v;
  endfunction

  always_comb begin
    accept  = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    a_neg   = rs1_signed(bus.funct3) && bus.rs1_data[XLEN-1];
    b_neg   = rs2_signed(bus.funct3) && bus.rs2_data[XLEN-1];
    a_mag   = a_neg ? -bus.rs1_data : bus.rs1_data;
    b_mag   = b_neg ? -bus.rs2_data : bus.rs2_data;
    div0    = is_div(bus.funct3) && (bus.rs2_data == '0);
    ovf     = (bus.funct3 == OP_DIV || bus.funct3 == OP_REM) &&
              (bus.rs1_data == INT_MIN) && (bus.rs2_data == '1);
    special = div0 || ovf;
    if (div0) special_res = is_rem(bus.funct3) ? bus.rs1_data : DIV0_QUOT;
    else      special_res = is_rem(bus.funct3) ? '0 : INT_MIN;
  end

  // Shift-add: add multiplicand into the upper half when the current multiplier bit is set
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    last     = (cnt_q == CW'(ITER - 1));
    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = neg_q ? -quo : quo;
    rem_fix  = dvd_neg_q ? -rem : rem;
    res_fix  = pick(op_q, prod_fix, quo_fix, rem_fix);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fa, fb;
  logic [2*XLEN-1:0]        fprod;
  logic [XLEN-1:0]          fast_res;

  // 33-bit signed operands (sign bit forced to 0 for unsigned sources), extended to product width
  always_comb begin
    fa       = {{XLEN{rs1_signed(bus.funct3) && bus.rs1_data[XLEN-1]}}, bus.rs1_data};
    fb       = {{XLEN{rs2_signed(bus.funct3) && bus.rs2_data[XLEN-1]}}, bus.rs2_data};
    fprod    = fa * fb;
    fast_res = pick(bus.funct3, fprod, '0, '0);
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    div_load = accept && is_div(bus.funct3);
    div_step = (state_q == ST_DIV);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (special)                 state_d = ST_DONE;
          else if (is_div(bus.funct3)) state_d = ST_DIV;
`ifdef MULDIV_FAST_MUL_EN
          else                         state_d = ST_DONE;
`else
          else                         state_d = ST_MUL;
`endif
        end
      end
      ST_MUL:  if (last) state_d = ST_FIX;
      ST_DIV:  if (last) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q      <= OP_MUL;
      mcand_q   <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      rd_q      <= '0;
      rd_out_q  <= '0;
      result_q  <= '0;
    end else if (accept) begin
      op_q      <= bus.funct3;
      mcand_q   <= a_mag;
      prod_q    <= {{XLEN{1'b0}}, b_mag};
      cnt_q     <= '0;
      neg_q     <= a_neg ^ b_neg;
      dvd_neg_q <= a_neg;
      rd_q      <= bus.rd_in;
      if (special) begin
        result_q <= special_res;
        rd_out_q <= bus.rd_in;
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (!is_div(bus.funct3)) begin
        result_q <= fast_res;
        rd_out_q <= bus.rd_in;
      end
`endif
    end else if (state_q == ST_MUL) begin
      prod_q <= {mul_sum, prod_q[XLEN-1:1]};
      cnt_q  <= cnt_q + CW'(1);
    end else if (state_q == ST_DIV) begin
      cnt_q  <= cnt_q + CW'(1);
    end else if (state_q == ST_FIX) begin
      result_q <= res_fix;
      rd_out_q <= rd_q;
    end
  end

  seq_divider #(.WIDTH(XLEN)) u_div (
    .clock     (clock),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  assign bus.busy   = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency, held-start, abort, back-to-back.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  localparam int LAT = 34;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  exp_t sb_q[$];
  exp_t mon_e;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (!reset && bus.done) begin
      check("done has pending op", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("result", bus.result, mon_e.res);
        check("rd_out", 32'(bus.rd_out), 32'(mon_e.rd));
      end
    end
  end

  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res);
    exp_t e;
    bus.start    = 1'b1;
    bus.funct3   = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in    = rd;
    e.res = res;
    e.rd  = rd;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    int busy_n = 0;
    do begin
      @(negedge clock);
      bus.start = 1'b0;
      n++;
      if (bus.busy) busy_n++;
    end while (!bus.done && n < 60);
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " busy cycles"}, 32'(busy_n), 32'(exp_lat - 1));
  endtask

  task automatic run_op(input string name, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                        input int exp_lat);
    @(negedge clock);
    issue(op, a, b, rd, res);
    wait_done(name, exp_lat);
    @(negedge clock);
    check({name, " done width"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.start    = 1'b0;
    bus.funct3   = OP_MUL;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_in    = '0;
    #22;
    check("reset busy",   32'(bus.busy),   32'd0);
    check("reset done",   32'(bus.done),   32'd0);
    check("reset result", bus.result,      32'd0);
    check("reset rd_out", 32'(bus.rd_out), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("mul 7x6",       OP_MUL,    32'd7,          32'd6,          5'd3,  32'd42,         MUL_LAT);
    run_op("mul -3x5",      OP_MUL,    32'hFFFF_FFFD,  32'd5,          5'd4,  32'hFFFF_FFF1,  MUL_LAT);
    run_op("mulh min*min",  OP_MULH,   32'h8000_0000,  32'h8000_0000,  5'd5,  32'h4000_0000,  MUL_LAT);
    run_op("mulhu max*max", OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'hFFFF_FFFE,  MUL_LAT);
    run_op("mulhsu -1*max", OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  32'hFFFF_FFFF,  MUL_LAT);
    run_op("div -7/2",      OP_DIV,    32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFD,  LAT);
    run_op("rem -7%2",      OP_REM,    32'hFFFF_FFF9,  32'd2,          5'd9,  32'hFFFF_FFFF,  LAT);
    run_op("divu 100/7",    OP_DIVU,   32'd100,        32'd7,          5'd10, 32'd14,         LAT);
    run_op("remu 100%7",    OP_REMU,   32'd100,        32'd7,          5'd11, 32'd2,          LAT);
    run_op("divu 5/0",      OP_DIVU,   32'd5,          32'd0,          5'd12, 32'hFFFF_FFFF,  1);
    run_op("rem 5%0",       OP_REM,    32'd5,          32'd0,          5'd13, 32'd5,          1);
    run_op("div ovf",       OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h8000_0000,  1);
    run_op("rem ovf",       OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'd0,          1);

    // start held high through most of the operation: exactly one op
    @(negedge clock);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd16, 32'd14);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 20) bus.start = 1'b0;
    end while (!bus.done && lat < 60);
    check("held start latency", 32'(lat), 32'(LAT));
    repeat (3) @(negedge clock);
    check("held start idle after", 32'(bus.busy), 32'd0);

    // asynchronous reset during a divide
    @(negedge clock);
    issue(OP_DIV, 32'd100, 32'd7, 5'd17, 32'd14);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    check("busy before abort", 32'(bus.busy), 32'd1);
    check("result before abort", bus.result, 32'd14);
    void'(sb_q.pop_back());
    #2 reset = 1'b1;
    #1;
    check("abort busy",   32'(bus.busy),   32'd0);
    check("abort done",   32'(bus.done),   32'd0);
    check("abort result", bus.result,      32'd0);
    check("abort rd_out", 32'(bus.rd_out), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("idle after abort", 32'(bus.busy), 32'd0);

    run_op("post-reset divu", OP_DIVU, 32'd1000, 32'd10, 5'd18, 32'd100, LAT);

    // back-to-back: new start in the done cycle
    @(negedge clock);
    issue(OP_REMU, 32'd100, 32'd7, 5'd20, 32'd2);
    wait_done("b2b first", LAT);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd21, 32'hFFFF_FFFD);
    wait_done("b2b second", LAT);
    issue(OP_DIVU, 32'd5, 32'd0, 5'd22, 32'hFFFF_FFFF);
    wait_done("b2b special", 1);
    @(negedge clock);
    check("b2b done width", 32'(bus.done), 32'd0);

    repeat (5) @(negedge clock);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
